// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the digit-serial packed-BCD adder.
package bcd_serial_adder_pkg;

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned BCD_MAX = 9;
  localparam int unsigned BCD_ADJ = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when a nibble is not a legal decimal digit.
  function automatic logic nib_invalid(input logic [NIB_W-1:0] n);
    return n > NIB_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add_ci.sv
// One-digit BCD add with carry-in and decimal correction.
module bcd_digit_add_ci
  import bcd_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] sum,
  output logic             co
);

  logic [NIB_W:0] s_c;

  // Binary digit sum, then +6 correction when it exceeds a decimal digit.
  always_comb begin
    s_c = (NIB_W+1)'(a) + (NIB_W+1)'(b) + (NIB_W+1)'(ci);
    co  = s_c > (NIB_W+1)'(BCD_MAX);
    sum = co ? NIB_W'(s_c + (NIB_W+1)'(BCD_ADJ)) : s_c[NIB_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, LSD first.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int unsigned DIGITS = 4
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NIB_W*DIGITS-1:0]   a,
  input  logic [NIB_W*DIGITS-1:0]   b,
  output logic                      busy,
  output logic                      done,
  output logic [NIB_W*DIGITS-1:0]   sum,
  output logic                      carry_out,
  output logic                      invalid
);

  localparam int unsigned W  = NIB_W * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  state_t          state_q;
  state_t          state_d;
  logic            accept_c;
  logic            step_c;
  logic            last_c;

  logic [W-1:0]    opa_q;
  logic [W-1:0]    opb_q;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    acc_next_c;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;
  logic            inv_pend_q;
  logic            inv_scan_c;

  logic [NIB_W-1:0] digit_c;
  logic             dco_c;

  // Single-digit adder working on the current low nibbles.
  bcd_digit_add_ci u_digit (
    .a   (opa_q[NIB_W-1:0]),
    .b   (opb_q[NIB_W-1:0]),
    .ci  (carry_q),
    .sum (digit_c),
    .co  (dco_c)
  );

  // New digit enters at the MSD end so digit 0 ends in the low nibble.
  always_comb begin
    acc_next_c = W'({digit_c, acc_q} >> NIB_W);
  end

  // Flag any non-decimal nibble in the operands offered with start.
  always_comb begin
    inv_scan_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (nib_invalid(a[NIB_W*i +: NIB_W]) || nib_invalid(b[NIB_W*i +: NIB_W])) begin
        inv_scan_c = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = ADD;
        end
      end
      ADD: begin
        step_c = 1'b1;
        if (cnt_q == CW'(DIGITS - 1)) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = ADD;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, digit stepping and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
    end else if (accept_c) begin
      opa_q      <= a;
      opb_q      <= b;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      inv_pend_q <= inv_scan_c;
    end else if (step_c) begin
      opa_q      <= opa_q >> NIB_W;
      opb_q      <= opb_q >> NIB_W;
      acc_q      <= acc_next_c;
      carry_q    <= dco_c;
      cnt_q      <= cnt_q + CW'(1);
    end
  end

  // Result and status outputs; result held until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      busy <= (state_d == ADD);
      done <= (state_d == DONE);
      if (last_c) begin
        sum       <= acc_next_c;
        carry_out <= dco_c;
        invalid   <= inv_pend_q;
      end
    end
  end

endmodule
